// File: rtl/video_timing_ctrl_if.sv
// Signal bundle between the video timing sequencer and its downstream sinks.
// VIDEO_TIMING_CTRL_PATTERN_EN adds the colour-bar pixel outputs oR0/oG0/oB0.
interface video_timing_ctrl_if #(
    parameter int CNT_WIDTH = 12
`ifdef VIDEO_TIMING_CTRL_PATTERN_EN
    ,
    parameter int PIXEL_WIDTH = 8
`endif
);
    // No valid/ready pair here: iENABLE is a level request sampled every clock and
    // acted on only at frame boundaries; all o* signals are registered, one-clock latency.
    logic                 iENABLE;
    logic                 oRUN;
    logic                 oHSYNC;
    logic                 oVSYNC;
    logic                 oDE;
    logic [CNT_WIDTH-1:0] oHCOUNT;
    logic [CNT_WIDTH-1:0] oVCOUNT;
    logic                 oFRAME_START;
    logic                 oLINE_START;
    logic [1:0]           dbg_state;
`ifdef VIDEO_TIMING_CTRL_PATTERN_EN
    logic [PIXEL_WIDTH-1:0] oR0;
    logic [PIXEL_WIDTH-1:0] oG0;
    logic [PIXEL_WIDTH-1:0] oB0;
`endif

    modport master (
        input  iENABLE,
        output oRUN, oHSYNC, oVSYNC, oDE, oHCOUNT, oVCOUNT,
        output oFRAME_START, oLINE_START, dbg_state
`ifdef VIDEO_TIMING_CTRL_PATTERN_EN
        ,
        output oR0, oG0, oB0
`endif
    );

    modport slave (
        output iENABLE,
        input  oRUN, oHSYNC, oVSYNC, oDE, oHCOUNT, oVCOUNT,
        input  oFRAME_START, oLINE_START, dbg_state
`ifdef VIDEO_TIMING_CTRL_PATTERN_EN
        ,
        input  oR0, oG0, oB0
`endif
    );
endinterface

// File: rtl/video_timing_ctrl.sv
// Video timing sequencer: HSYNC/VSYNC/DE, active coordinates and frame/line strobes.
// VIDEO_TIMING_CTRL_PATTERN_EN adds an 8-bar colour pattern on oR0/oG0/oB0.
module video_timing_ctrl #(
    parameter int CNT_WIDTH = 12,
    parameter int H_ACTIVE  = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_ACTIVE  = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33,
    parameter bit HS_POL    = 1'b0,
    parameter bit VS_POL    = 1'b0
`ifdef VIDEO_TIMING_CTRL_PATTERN_EN
    ,
    parameter int PIXEL_WIDTH = 8
`endif
) (
    input logic                 CLK,
    input logic                 RST,
    video_timing_ctrl_if.master vif
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    if ((H_TOTAL > (1 << CNT_WIDTH)) || (V_TOTAL > (1 << CNT_WIDTH))) begin : g_size_check
        $error("video_timing_ctrl: H_TOTAL/V_TOTAL do not fit in CNT_WIDTH");
    end

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, STOPPING = 2'd2} state_e;

    state_e               state_q, state_d;
    logic [CNT_WIDTH-1:0] hcnt_q, hcnt_d, vcnt_q, vcnt_d;
    logic                 h_last, v_last, h_act, v_act, h_sync, v_sync;

    logic                 run_q, run_d, hsync_q, hsync_d, vsync_q, vsync_d, de_q, de_d;
    logic [CNT_WIDTH-1:0] hcount_q, hcount_d, vcount_q, vcount_d;
    logic                 fs_q, fs_d, ls_q, ls_d;

    always_comb begin
        h_last = (hcnt_q == CNT_WIDTH'(H_TOTAL - 1));
        v_last = (vcnt_q == CNT_WIDTH'(V_TOTAL - 1));
        h_act  = (hcnt_q < CNT_WIDTH'(H_ACTIVE));
        v_act  = (vcnt_q < CNT_WIDTH'(V_ACTIVE));
        h_sync = (hcnt_q >= CNT_WIDTH'(H_ACTIVE + H_FP)) &&
                 (hcnt_q <  CNT_WIDTH'(H_ACTIVE + H_FP + H_SYNC));
        v_sync = (vcnt_q >= CNT_WIDTH'(V_ACTIVE + V_FP)) &&
                 (vcnt_q <  CNT_WIDTH'(V_ACTIVE + V_FP + V_SYNC));
    end

    // Next state and counters. A stop only exits on the last clock of a frame;
    // an enable seen on that same clock keeps frames running back-to-back.
    always_comb begin
        state_d = state_q;
        hcnt_d  = hcnt_q;
        vcnt_d  = vcnt_q;
        if (state_q != IDLE) begin
            hcnt_d = h_last ? '0 : hcnt_q + 1'b1;
            if (h_last) begin
                vcnt_d = v_last ? '0 : vcnt_q + 1'b1;
            end
        end
        case (state_q)
            IDLE: begin
                if (vif.iENABLE) state_d = RUN;
            end
            RUN: begin
                if (!vif.iENABLE) state_d = STOPPING;
            end
            STOPPING: begin
                if (vif.iENABLE) begin
                    state_d = RUN;
                end else if (h_last && v_last) begin
                    state_d = IDLE;
                    hcnt_d  = '0;
                    vcnt_d  = '0;
                end
            end
            default: begin
                state_d = IDLE;
                hcnt_d  = '0;
                vcnt_d  = '0;
            end
        endcase
    end

    always_comb begin
        run_d    = 1'b0;
        hsync_d  = ~HS_POL;
        vsync_d  = ~VS_POL;
        de_d     = 1'b0;
        hcount_d = '0;
        vcount_d = '0;
        fs_d     = 1'b0;
        ls_d     = 1'b0;
        if (state_q != IDLE) begin
            run_d    = 1'b1;
            de_d     = h_act && v_act;
            hsync_d  = h_sync ? HS_POL : ~HS_POL;
            vsync_d  = v_sync ? VS_POL : ~VS_POL;
            hcount_d = de_d ? hcnt_q : '0;
            vcount_d = de_d ? vcnt_q : '0;
            ls_d     = de_d && (hcnt_q == '0);
            fs_d     = ls_d && (vcnt_q == '0);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= IDLE;
            hcnt_q   <= '0;
            vcnt_q   <= '0;
            run_q    <= 1'b0;
            hsync_q  <= ~HS_POL;
            vsync_q  <= ~VS_POL;
            de_q     <= 1'b0;
            hcount_q <= '0;
            vcount_q <= '0;
            fs_q     <= 1'b0;
            ls_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            hcnt_q   <= hcnt_d;
            vcnt_q   <= vcnt_d;
            run_q    <= run_d;
            hsync_q  <= hsync_d;
            vsync_q  <= vsync_d;
            de_q     <= de_d;
            hcount_q <= hcount_d;
            vcount_q <= vcount_d;
            fs_q     <= fs_d;
            ls_q     <= ls_d;
        end
    end

    assign vif.oRUN         = run_q;
    assign vif.oHSYNC       = hsync_q;
    assign vif.oVSYNC       = vsync_q;
    assign vif.oDE          = de_q;
    assign vif.oHCOUNT      = hcount_q;
    assign vif.oVCOUNT      = vcount_q;
    assign vif.oFRAME_START = fs_q;
    assign vif.oLINE_START  = ls_q;
    assign vif.dbg_state    = state_q;

`ifdef VIDEO_TIMING_CTRL_PATTERN_EN
    // Bars are H_ACTIVE/8 wide; any remainder pixels stay in the last bar.
    localparam int BAR_W = (H_ACTIVE >= 8) ? (H_ACTIVE / 8) : 1;

    logic [CNT_WIDTH-1:0]   bar_full;
    logic [2:0]             bar;
    logic [PIXEL_WIDTH-1:0] r_q, r_d, g_q, g_d, b_q, b_d;

    always_comb begin
        bar_full = hcnt_q / CNT_WIDTH'(BAR_W);
        bar      = (bar_full > CNT_WIDTH'(7)) ? 3'd7 : bar_full[2:0];
        r_d      = (de_d && bar[2]) ? '1 : '0;
        g_d      = (de_d && bar[1]) ? '1 : '0;
        b_d      = (de_d && bar[0]) ? '1 : '0;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_q <= '0;
            g_q <= '0;
            b_q <= '0;
        end else begin
            r_q <= r_d;
            g_q <= g_d;
            b_q <= b_d;
        end
    end

    assign vif.oR0 = r_q;
    assign vif.oG0 = g_q;
    assign vif.oB0 = b_q;
`endif
endmodule

// File: tb/tb_video_timing_ctrl.sv
// Bench for video_timing_ctrl: frame-position reference model plus directed and random stimulus.
// Define VIDEO_TIMING_CTRL_PATTERN_EN to exercise the colour-bar outputs (H_ACTIVE becomes 16).
module tb_video_timing_ctrl;
    localparam int CW  = 12;
`ifdef VIDEO_TIMING_CTRL_PATTERN_EN
    localparam int HA  = 16;
`else
    localparam int HA  = 4;
`endif
    localparam int HFP = 1, HSW = 2, HBP = 1;
    localparam int VA  = 3, VFP = 1, VSW = 1, VBP = 1;
    localparam int HT    = HA + HFP + HSW + HBP;
    localparam int VT    = VA + VFP + VSW + VBP;
    localparam int FRAME = HT * VT;
    localparam int PW    = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;
    bit   chk_en   = 1'b0;

    always #5 clk = ~clk;

    video_timing_ctrl_if #(
        .CNT_WIDTH(CW)
`ifdef VIDEO_TIMING_CTRL_PATTERN_EN
        , .PIXEL_WIDTH(PW)
`endif
    ) vif ();

    video_timing_ctrl #(
        .CNT_WIDTH(CW), .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
        .HS_POL(1'b0), .VS_POL(1'b0)
`ifdef VIDEO_TIMING_CTRL_PATTERN_EN
        , .PIXEL_WIDTH(PW)
`endif
    ) dut (
        .CLK(clk),
        .RST(rst),
        .vif(vif)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a running flag, a pending-stop flag and a position 0..FRAME-1
    // inside the frame; outputs are derived from (x, y) = (pos % HT, pos / HT).
    bit m_run, m_pend;
    int m_pos, mx, my, bar;
    bit e_run, e_hs, e_vs, e_de, e_fs, e_ls;
    int e_hc, e_vc, e_r, e_g, e_b;

    always @(posedge clk) begin
        if (rst) begin
            m_run = 0; m_pend = 0; m_pos = 0;
            e_run = 0; e_hs = 1; e_vs = 1; e_de = 0; e_fs = 0; e_ls = 0;
            e_hc = 0; e_vc = 0; e_r = 0; e_g = 0; e_b = 0;
        end else begin
            mx    = m_pos % HT;
            my    = m_pos / HT;
            e_run = m_run;
            e_de  = m_run && (mx < HA) && (my < VA);
            e_hs  = !(m_run && (mx >= HA + HFP) && (mx < HA + HFP + HSW));
            e_vs  = !(m_run && (my >= VA + VFP) && (my < VA + VFP + VSW));
            e_hc  = e_de ? mx : 0;
            e_vc  = e_de ? my : 0;
            e_ls  = e_de && (mx == 0);
            e_fs  = e_ls && (my == 0);
            bar   = (HA >= 8) ? mx / (HA / 8) : mx;
            if (bar > 7) bar = 7;
            e_r   = (e_de && bar[2]) ? 255 : 0;
            e_g   = (e_de && bar[1]) ? 255 : 0;
            e_b   = (e_de && bar[0]) ? 255 : 0;
            if (!m_run) begin
                if (vif.iENABLE) begin m_run = 1; m_pos = 0; m_pend = 0; end
            end else if (m_pend && !vif.iENABLE && (m_pos == FRAME - 1)) begin
                m_run = 0; m_pos = 0; m_pend = 0;
            end else begin
                m_pos  = (m_pos + 1) % FRAME;
                m_pend = !vif.iENABLE;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("run",    vif.oRUN,         e_run);
            check("hsync",  vif.oHSYNC,       e_hs);
            check("vsync",  vif.oVSYNC,       e_vs);
            check("de",     vif.oDE,          e_de);
            check("hcount", vif.oHCOUNT,      e_hc);
            check("vcount", vif.oVCOUNT,      e_vc);
            check("fstart", vif.oFRAME_START, e_fs);
            check("lstart", vif.oLINE_START,  e_ls);
            check("busy",   vif.dbg_state != 2'd0, m_run);
`ifdef VIDEO_TIMING_CTRL_PATTERN_EN
            check("red",    vif.oR0, e_r);
            check("green",  vif.oG0, e_g);
            check("blue",   vif.oB0, e_b);
`endif
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        vif.iENABLE = 1'b0;
        step(2);
        rst = 1'b0;
    endtask

    // Leaves the bench at the negedge showing the first DE pixel (k = 0).
    task automatic start_frames();
        do_reset();
        vif.iENABLE = 1'b1;
        step(2);
    endtask

    int fs_k[$];
    int n_ls, n_vs, de_idx, n_fs;

    initial begin
        vif.iENABLE = 1'b0;
        do_reset();
        chk_en = 1'b1;

        // Test 1: reset values, first-frame latency and one line's timing
        check("rst_run", vif.oRUN, 0);
        check("rst_de", vif.oDE, 0);
        check("rst_hsync", vif.oHSYNC, 1);
        check("rst_vsync", vif.oVSYNC, 1);
        check("rst_hcount", vif.oHCOUNT, 0);
        check("rst_state", vif.dbg_state, 0);
        vif.iENABLE = 1'b1;
        step(1);
        check("lat_run_low", vif.oRUN, 0);
        check("lat_de_low", vif.oDE, 0);
        step(1);
        check("first_run", vif.oRUN, 1);
        check("first_de", vif.oDE, 1);
        check("first_fs", vif.oFRAME_START, 1);
        check("first_hc", vif.oHCOUNT, 0);
        check("first_vc", vif.oVCOUNT, 0);
        step(HA - 1);
        check("de_last_px", vif.oDE, 1);
        check("hc_last_px", vif.oHCOUNT, HA - 1);
        step(1);
        check("de_fp", vif.oDE, 0);
        check("hc_blank", vif.oHCOUNT, 0);
        step(HFP);
        check("hsync_first", vif.oHSYNC, 0);
        step(HSW - 1);
        check("hsync_last", vif.oHSYNC, 0);
        step(1);
        check("hsync_bp", vif.oHSYNC, 1);

        // Test 2: three back-to-back frames
        start_frames();
        n_ls = 0; n_vs = 0; de_idx = 0;
        for (int k = 0; k < 3 * FRAME; k++) begin
            if (vif.oFRAME_START) fs_k.push_back(k);
            if (vif.oLINE_START) n_ls++;
            if (vif.oVSYNC == 1'b0) n_vs++;
            if (vif.oDE && k < FRAME) begin
                check("hcount_seq", vif.oHCOUNT, de_idx % HA);
                check("vcount_seq", vif.oVCOUNT, de_idx / HA);
                de_idx++;
            end
`ifdef VIDEO_TIMING_CTRL_PATTERN_EN
            if (k == 0) check("bar0_rgb", {vif.oR0, vif.oG0, vif.oB0}, 24'h000000);
            if (k == 2) check("bar1_rgb", {vif.oR0, vif.oG0, vif.oB0}, 24'h0000FF);
            if (k == 4) check("bar2_rgb", {vif.oR0, vif.oG0, vif.oB0}, 24'h00FF00);
            if (k == 14) check("bar7_rgb", {vif.oR0, vif.oG0, vif.oB0}, 24'hFFFFFF);
            if (k == HA) check("bar_blank", {vif.oR0, vif.oG0, vif.oB0}, 24'h000000);
`endif
            step(1);
        end
        check("fs_count", fs_k.size(), 3);
        check("ls_count", n_ls, 3 * VA);
        check("vs_clocks", n_vs, 3 * VSW * HT);
        check("de_pixels", de_idx, HA * VA);
        if (fs_k.size() == 3) begin
            check("fs_first", fs_k[0], 0);
            check("fs_period1", fs_k[1] - fs_k[0], FRAME);
            check("fs_period2", fs_k[2] - fs_k[1], FRAME);
        end

        // Test 3: stop request mid-frame completes the frame, then idles
        start_frames();
        step(10);
        vif.iENABLE = 1'b0;
        step(FRAME - 1 - 10);
        check("stop_last_run", vif.oRUN, 1);
        step(1);
        check("stop_run", vif.oRUN, 0);
        check("stop_hsync", vif.oHSYNC, 1);
        check("stop_vsync", vif.oVSYNC, 1);
        n_fs = 0;
        for (int k = 0; k < 2 * FRAME; k++) begin
            if (vif.oFRAME_START) n_fs++;
            step(1);
        end
        check("stop_no_fs", n_fs, 0);

        // Test 4: stop withdrawn before frame end
        start_frames();
        step(10);
        vif.iENABLE = 1'b0;
        step(10);
        vif.iENABLE = 1'b1;
        step(FRAME - 20);
        check("resume_fs", vif.oFRAME_START, 1);
        n_fs = 0;
        for (int k = 0; k < FRAME; k++) begin
            if (!vif.oRUN) n_fs++;
            step(1);
        end
        check("resume_run_gaps", n_fs, 0);
        check("resume_fs2", vif.oFRAME_START, 1);

        // Test 5: reset in the middle of active line 2
        start_frames();
        step(2 * HT + 1);
        check("mid_de", vif.oDE, 1);
        check("mid_vc", vif.oVCOUNT, 2);
        rst = 1'b1;
        step(1);
        check("rst_mid_de", vif.oDE, 0);
        check("rst_mid_hs", vif.oHSYNC, 1);
        check("rst_mid_vs", vif.oVSYNC, 1);
        check("rst_mid_run", vif.oRUN, 0);
        check("rst_mid_hc", vif.oHCOUNT, 0);
        check("rst_mid_vc", vif.oVCOUNT, 0);
        rst = 1'b0;

        // Random enable toggling with occasional resets, checked by the model
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 99) < 3) vif.iENABLE = ~vif.iENABLE;
            rst = ($urandom_range(0, 999) < 2);
            step(1);
        end
        rst = 1'b0;
        step(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
